lc4_mem_arbiter: RTL and testbench

LC4_MEM_ARBITER -- requirements
Module: lc4_mem_arbiter

---
 rtl/lc4_mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_lc4_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc4_mem_arbiter.sv
// rtl/lc4_mem_arbiter.sv - fetch/data arbiter in front of a shared single-port memory
//
// Two requesters share one memory port.  Data requests normally win, but a
// starvation counter lets the fetch port in after STARVE_MAX consecutive data
// grants that were made while fetch was waiting.  Every transaction runs
// IDLE -> RD/WR -> ACK -> IDLE.  Address, write data and requester are latched
// at the grant edge, so requester changes after that point are ignored.
//
// Parameters
//   WORD_SIZE  : data word width (>= 16, fetch uses the low 16 bits)
//   LATENCY    : memory read latency in cycles, 1..7
//   STARVE_MAX : data grants allowed while fetch waits, 1..15
//
// Ports
//   clk, rst                       : clock, asynchronous active-low reset
//   i_fetch_req/addr               : fetch request and address
//   o_fetch_ack/insn               : fetch completion pulse and instruction
//   i_data_req/we/addr/wdata       : data request, write flag, address, data
//   o_data_ack/rdata               : data completion pulse and read data
//   o_mem_re/we/addr/wdata         : memory strobe, address and write data
//   i_mem_rdata                    : memory read data
//   o_stall                        : 1 while fetch is requested but not acked

module lc4_mem_arbiter #(
    parameter int WORD_SIZE  = 64,
    parameter int LATENCY    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 i_fetch_req,
    input  logic [15:0]          i_fetch_addr,
    output logic                 o_fetch_ack,
    output logic [15:0]          o_fetch_insn,

    input  logic                 i_data_req,
    input  logic                 i_data_we,
    input  logic [15:0]          i_data_addr,
    input  logic [WORD_SIZE-1:0] i_data_wdata,
    output logic                 o_data_ack,
    output logic [WORD_SIZE-1:0] o_data_rdata,

    output logic                 o_mem_re,
    output logic                 o_mem_we,
    output logic [15:0]          o_mem_addr,
    output logic [WORD_SIZE-1:0] o_mem_wdata,
    input  logic [WORD_SIZE-1:0] i_mem_rdata,

    output logic [1:0]           o_stall
);

    localparam logic [2:0] LAT_LAST   = 3'(LATENCY);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        ACK  = 2'd3
    } state_t;

    state_t                 state_q,       state_d;
    logic [2:0]             lat_cnt_q,     lat_cnt_d;
    logic [3:0]             starve_q,      starve_d;
    logic                   gnt_fetch_q,   gnt_fetch_d;
    logic [15:0]            addr_q,        addr_d;
    logic [WORD_SIZE-1:0]   wdata_q,       wdata_d;
    logic [15:0]            fetch_insn_q,  fetch_insn_d;
    logic [WORD_SIZE-1:0]   data_rdata_q,  data_rdata_d;

    logic fetch_wins;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            lat_cnt_q    <= '0;
            starve_q     <= '0;
            gnt_fetch_q  <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            fetch_insn_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_q     <= starve_d;
            gnt_fetch_q  <= gnt_fetch_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            fetch_insn_q <= fetch_insn_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        starve_d     = starve_q;
        gnt_fetch_d  = gnt_fetch_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        fetch_insn_d = fetch_insn_q;
        data_rdata_d = data_rdata_q;

        // Fetch takes the port when it is alone or has been passed over
        // STARVE_MAX times in a row.
        fetch_wins = i_fetch_req && (!i_data_req || (starve_q == STARVE_LIM));

        unique case (state_q)
            IDLE: begin
                if (i_fetch_req || i_data_req) begin
                    lat_cnt_d = '0;
                    if (fetch_wins) begin
                        gnt_fetch_d = 1'b1;
                        addr_d      = i_fetch_addr;
                        wdata_d     = '0;
                        starve_d    = '0;
                        state_d     = RD;
                    end else begin
                        gnt_fetch_d = 1'b0;
                        addr_d      = i_data_addr;
                        wdata_d     = i_data_we ? i_data_wdata : '0;
                        state_d     = i_data_we ? WR : RD;
                        // Only grants that kept fetch waiting count as starvation.
                        if (i_fetch_req && (starve_q != STARVE_LIM)) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end
                end
            end
            RD: begin
                // lat_cnt 0 is the strobe cycle; data is valid in cycle LATENCY.
                if (lat_cnt_q == LAT_LAST) begin
                    state_d = ACK;
                    if (gnt_fetch_q) begin
                        fetch_insn_d = i_mem_rdata[15:0];
                    end else begin
                        data_rdata_d = i_mem_rdata;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end
            WR: begin
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_mem_re     = (state_q == RD) && (lat_cnt_q == 3'd0);
    assign o_mem_we     = (state_q == WR);
    assign o_mem_addr   = (o_mem_re || o_mem_we) ? addr_q : 16'h0000;
    assign o_mem_wdata  = o_mem_we ? wdata_q : '0;

    assign o_fetch_ack  = (state_q == ACK) &&  gnt_fetch_q;
    assign o_data_ack   = (state_q == ACK) && !gnt_fetch_q;
    assign o_fetch_insn = fetch_insn_q;
    assign o_data_rdata = data_rdata_q;

    // Gated by rst so every output reads 0 while reset is held.
    assign o_stall      = {1'b0, rst & i_fetch_req & ~o_fetch_ack};

endmodule

// File: tb/tb_lc4_mem_arbiter.sv
// tb/tb_lc4_mem_arbiter.sv - scoreboard bench for lc4_mem_arbiter
module tb_lc4_mem_arbiter;

    localparam int WS  = 64;
    localparam int LAT = 2;
    localparam int SMX = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_fetch_req = 1'b0;
    logic [15:0]   i_fetch_addr = '0;
    logic          o_fetch_ack;
    logic [15:0]   o_fetch_insn;
    logic          i_data_req = 1'b0;
    logic          i_data_we = 1'b0;
    logic [15:0]   i_data_addr = '0;
    logic [WS-1:0] i_data_wdata = '0;
    logic          o_data_ack;
    logic [WS-1:0] o_data_rdata;
    logic          o_mem_re;
    logic          o_mem_we;
    logic [15:0]   o_mem_addr;
    logic [WS-1:0] o_mem_wdata;
    logic [WS-1:0] i_mem_rdata = '0;
    logic [1:0]    o_stall;

    lc4_mem_arbiter #(.WORD_SIZE(WS), .LATENCY(LAT), .STARVE_MAX(SMX)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_fetch_req  (i_fetch_req),
        .i_fetch_addr (i_fetch_addr),
        .o_fetch_ack  (o_fetch_ack),
        .o_fetch_insn (o_fetch_insn),
        .i_data_req   (i_data_req),
        .i_data_we    (i_data_we),
        .i_data_addr  (i_data_addr),
        .i_data_wdata (i_data_wdata),
        .o_data_ack   (o_data_ack),
        .o_data_rdata (o_data_rdata),
        .o_mem_re     (o_mem_re),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_rdata  (i_mem_rdata),
        .o_stall      (o_stall)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] mem_val(input logic [15:0] a);
        if (a == 16'h8200) return 64'h0000_0000_0000_1234;
        return {a, ~a, a ^ 16'h5A5A, a + 16'h0001};
    endfunction

    logic [15:0] fetch_exp_q[$];
    logic [63:0] data_exp_q[$];
    logic [79:0] wr_exp_q[$];
    bit          grant_log[$];
    logic [63:0] last_rd = '0;

    // Memory model: read data is valid only in cycle G+LAT, noise otherwise.
    int          rsp_cd = 0;
    logic [15:0] rsp_addr = '0;
    logic        rsp_hit;
    always @(posedge clk) begin
        #1;
        rsp_hit = 1'b0;
        if (rsp_cd > 0) begin
            rsp_cd  = rsp_cd - 1;
            rsp_hit = (rsp_cd == 0);
        end
        i_mem_rdata = rsp_hit ? mem_val(rsp_addr) : {$urandom, $urandom};
        if (o_mem_re) begin
            rsp_cd   = LAT;
            rsp_addr = o_mem_addr;
        end
    end

    always @(negedge clk) begin
        chk_eq("mem_re_we_excl", 80'(o_mem_re & o_mem_we), 80'(0));
        chk_eq("stall", 80'(o_stall), 80'({1'b0, rst & i_fetch_req & ~o_fetch_ack}));
        if (!o_mem_re && !o_mem_we)
            chk_eq("mem_idle_zero", 80'({o_mem_addr, o_mem_wdata}), 80'(0));
        if (o_mem_re || o_mem_we)
            grant_log.push_back(o_mem_addr[15]);
        if (o_mem_we) begin
            if (wr_exp_q.size() == 0) chk_eq("unexpected_write", 80'(wr_exp_q.size()), 80'(1));
            else chk_eq("mem_write", 80'({o_mem_addr, o_mem_wdata}), wr_exp_q.pop_front());
        end
        if (o_fetch_ack) begin
            if (fetch_exp_q.size() == 0) chk_eq("unexpected_fetch_ack", 80'(fetch_exp_q.size()), 80'(1));
            else chk_eq("fetch_insn", 80'(o_fetch_insn), 80'(fetch_exp_q.pop_front()));
        end
        if (o_data_ack) begin
            if (data_exp_q.size() == 0) chk_eq("unexpected_data_ack", 80'(data_exp_q.size()), 80'(1));
            else chk_eq("data_rdata", 80'(o_data_rdata), 80'(data_exp_q.pop_front()));
        end
    end

    task automatic fetch_txn(input logic [15:0] a);
        logic [63:0] v;
        int n;
        v = mem_val(a);
        i_fetch_req  = 1'b1;
        i_fetch_addr = a;
        fetch_exp_q.push_back(v[15:0]);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!o_fetch_ack && n < 40);
        chk_eq("fetch_ack_seen", 80'(o_fetch_ack), 80'(1));
        i_fetch_req = 1'b0;
    endtask

    task automatic data_txn(input logic we, input logic [15:0] a, input logic [63:0] wd);
        int n;
        i_data_req   = 1'b1;
        i_data_we    = we;
        i_data_addr  = a;
        i_data_wdata = wd;
        if (we) begin
            wr_exp_q.push_back({a, wd});
        end else begin
            last_rd = mem_val(a);
        end
        data_exp_q.push_back(last_rd);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!o_data_ack && n < 40);
        chk_eq("data_ack_seen", 80'(o_data_ack), 80'(1));
        i_data_req = 1'b0;
        i_data_we  = 1'b0;
    endtask

    initial begin
        int n;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_eq("reset_ctrl", 80'({o_mem_re, o_mem_we, o_fetch_ack, o_data_ack, o_stall}), 80'(0));
        chk_eq("reset_insn", 80'(o_fetch_insn), 80'(0));
        chk_eq("reset_rdata", 80'(o_data_rdata), 80'(0));
        rst = 1'b1;
        @(posedge clk); #1;

        // Fetch only, exact cycle timing
        i_fetch_req = 1'b1; i_fetch_addr = 16'h8200;
        fetch_exp_q.push_back(16'h1234);
        @(posedge clk); #1;
        chk_eq("f_g_re", 80'({o_mem_re, o_mem_addr}), 80'({1'b1, 16'h8200}));
        chk_eq("f_g_stall", 80'(o_stall), 80'(1));
        @(posedge clk); #1;
        chk_eq("f_g1_re_ack", 80'({o_mem_re, o_fetch_ack}), 80'(0));
        @(posedge clk); #1;
        chk_eq("f_g2_ack_stall", 80'({o_fetch_ack, o_stall}), 80'({1'b0, 2'd1}));
        @(posedge clk); #1;
        chk_eq("f_g3_ack_insn", 80'({o_fetch_ack, o_fetch_insn}), 80'({1'b1, 16'h1234}));
        chk_eq("f_g3_stall", 80'(o_stall), 80'(0));
        i_fetch_req = 1'b0;
        @(posedge clk); #1;
        chk_eq("f_idle_hold", 80'({o_fetch_ack, o_fetch_insn}), 80'({1'b0, 16'h1234}));

        // Data write
        i_data_req = 1'b1; i_data_we = 1'b1; i_data_addr = 16'h4000;
        i_data_wdata = 64'hDEAD_BEEF_0000_0001;
        wr_exp_q.push_back({16'h4000, 64'hDEAD_BEEF_0000_0001});
        data_exp_q.push_back(last_rd);
        @(posedge clk); #1;
        chk_eq("w_g", 80'({o_mem_re, o_mem_we, o_mem_addr}), 80'({2'b01, 16'h4000}));
        chk_eq("w_g_wdata", 80'(o_mem_wdata), 80'(64'hDEAD_BEEF_0000_0001));
        @(posedge clk); #1;
        chk_eq("w_ack", 80'({o_data_ack, o_data_rdata}), 80'({1'b1, 64'h0}));
        i_data_req = 1'b0; i_data_we = 1'b0;
        @(posedge clk); #1;

        // Simultaneous fetch and data read: data first
        grant_log.delete();
        fork
            fetch_txn(16'h8400);
            data_txn(1'b0, 16'h4020, 64'h0);
        join
        chk_eq("sim_grants", 80'(grant_log.size()), 80'(2));
        if (grant_log.size() == 2)
            chk_eq("sim_order", 80'({grant_log[0], grant_log[1]}), 80'(2'b01));
        @(posedge clk); #1;

        // Both held: four data grants, then fetch
        grant_log.delete();
        fork
            begin
                for (int k = 0; k < 2; k++) fetch_txn(16'h8500 + 16'(k));
            end
            begin
                for (int k = 0; k < 8; k++) data_txn(k[0], 16'h4100 + 16'(k), {32'hA5A5_0000, 32'(k)});
            end
        join
        chk_eq("starve_grants", 80'(grant_log.size()), 80'(10));
        for (int k = 0; k < grant_log.size(); k++)
            chk_eq($sformatf("starve_slot%0d", k), 80'(grant_log[k]), 80'((k % 5) == 4));
        @(posedge clk); #1;

        // Reset in the middle of a read
        i_fetch_req = 1'b1; i_fetch_addr = 16'h8300;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!o_mem_re && n < 10);
        chk_eq("rst_case_grant", 80'(o_mem_re), 80'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk_eq("rst_ctrl_zero", 80'({o_mem_re, o_mem_we, o_fetch_ack, o_data_ack, o_stall, o_mem_addr}), 80'(0));
        chk_eq("rst_insn_zero", 80'(o_fetch_insn), 80'(0));
        chk_eq("rst_rdata_zero", 80'(o_data_rdata), 80'(0));
        last_rd = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        fetch_exp_q.push_back(16'h8301);
        @(posedge clk); #1;
        chk_eq("rst_first_grant", 80'({o_mem_re, o_mem_addr}), 80'({1'b1, 16'h8300}));
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!o_fetch_ack && n < 10);
        chk_eq("rst_reissue_ack", 80'(o_fetch_ack), 80'(1));
        i_fetch_req = 1'b0;
        @(posedge clk); #1;

        // Requester changes after grant are ignored
        i_data_req = 1'b1; i_data_we = 1'b0; i_data_addr = 16'h4030;
        last_rd = mem_val(16'h4030);
        data_exp_q.push_back(last_rd);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!o_mem_re && n < 10);
        chk_eq("chg_grant", 80'(o_mem_re), 80'(1));
        @(negedge clk);
        i_data_addr = 16'h0001; i_data_we = 1'b1; i_data_wdata = 64'h1111_2222_3333_4444;
        #1;
        chk_eq("chg_latched_addr", 80'({o_mem_we, o_mem_addr}), 80'({1'b0, 16'h4030}));
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!o_data_ack && n < 10);
        chk_eq("chg_ack", 80'(o_data_ack), 80'(1));
        i_data_req = 1'b0; i_data_we = 1'b0;
        @(posedge clk); #1;

        // Random mixed traffic
        fork
            begin
                for (int k = 0; k < 70; k++) begin
                    automatic int g = $urandom_range(0, 3);
                    repeat (g) begin @(posedge clk); #1; end
                    fetch_txn({4'h8, 12'($urandom)});
                end
            end
            begin
                for (int k = 0; k < 90; k++) begin
                    automatic int g = $urandom_range(0, 3);
                    repeat (g) begin @(posedge clk); #1; end
                    data_txn(1'($urandom_range(0, 1)), {4'h4, 12'($urandom)}, {$urandom, $urandom});
                end
            end
        join

        repeat (5) @(posedge clk);
        #1;
        chk_eq("fetch_q_drained", 80'(fetch_exp_q.size()), 80'(0));
        chk_eq("data_q_drained", 80'(data_exp_q.size()), 80'(0));
        chk_eq("write_q_drained", 80'(wr_exp_q.size()), 80'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, checks %0d failures %0d", n_chk, n_fail);
        $fatal(1);
    end

endmodule
